// File: rtl/interp_hold_expander.sv
// interp_hold_expander: linear-interpolating upsampler with ready/valid on both sides.
// Each accepted input sample produces L = interp_factor+1 output beats. The beats ramp
// from the previous sample to the current one, and every beat is scaled by L
// (un-normalised). Only an add chain is used; there are no multipliers.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - asynchronous active-high reset
//   interp_factor  - L-1, sampled only when an input sample is accepted
//   in_data        - signed input sample
//   in_data_valid  - input sample valid
//   in_data_ready  - input accepted this cycle (combinational)
//   out_data       - signed interpolated sample (registered)
//   out_data_valid - out_data valid (registered)
//   out_data_ready - downstream accepts out_data
module interp_hold_expander #(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int FACTOR_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FACTOR_WIDTH-1:0]   interp_factor,
    input  logic [IN_DATA_WIDTH-1:0]  in_data,
    input  logic                      in_data_valid,
    output logic                      in_data_ready,
    output logic [OUT_DATA_WIDTH-1:0] out_data,
    output logic                      out_data_valid,
    input  logic                      out_data_ready
);

    localparam int IW = IN_DATA_WIDTH;
    localparam int OW = OUT_DATA_WIDTH;
    localparam int CW = FACTOR_WIDTH + 1;

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] delta_q, delta_d;
    logic [IW-1:0] prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] l_q, l_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic          out_fire;
    logic          in_fire;
    logic          last_beat;
    logic          hist_keep;
    logic [CW-1:0] l_new;
    logic [IW-1:0] prev_eff;
    logic [OW-1:0] acc_eff;
    logic [IW:0]   d_narrow;
    logic [OW-1:0] d_wide;
    logic [OW-1:0] load_sum;
    logic [OW-1:0] step_sum;

    assign out_data       = out_data_q;
    assign out_data_valid = out_valid_q;

    always_comb begin
        out_fire  = out_valid_q & out_data_ready;
        last_beat = (cnt_q == l_q);
        // Accept a new sample only when idle or when the final beat leaves this
        // cycle, so bursts chain back-to-back without a bubble.
        in_data_ready = ~rst & ((state_q == StIdle) |
                                ((state_q == StRun) & last_beat & out_fire));
        in_fire   = in_data_valid & in_data_ready;

        l_new     = {1'b0, interp_factor} + CW'(1);
        // A change of L invalidates the history: acc == prev*L_old no longer
        // matches the new scale, so restart the ramp from zero.
        hist_keep = (l_new == l_q);
        prev_eff  = hist_keep ? prev_q : '0;
        acc_eff   = hist_keep ? acc_q : '0;

        // One extra bit is enough for the exact difference of two IW-bit values.
        d_narrow  = {in_data[IW-1], in_data} - {prev_eff[IW-1], prev_eff};
        d_wide    = {{(OW - IW - 1){d_narrow[IW]}}, d_narrow};
        load_sum  = acc_eff + d_wide;
        step_sum  = acc_q + delta_q;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        delta_d     = delta_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (in_fire) begin
            delta_d     = d_wide;
            acc_d       = load_sum;
            out_data_d  = load_sum;
            out_valid_d = 1'b1;
            cnt_d       = CW'(1);
            prev_d      = in_data;
            l_d         = l_new;
            state_d     = StRun;
        end else if ((state_q == StRun) && out_fire) begin
            if (!last_beat) begin
                acc_d      = step_sum;
                out_data_d = step_sum;
                cnt_d      = cnt_q + CW'(1);
            end else begin
                // Burst done, nothing queued: out_data keeps its last value.
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            delta_q     <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            l_q         <= CW'(1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            delta_q     <= delta_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_interp_hold_expander.sv
module tb_interp_hold_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] interp_factor;
    logic [15:0] in_data;
    logic        in_data_valid;
    logic        in_data_ready;
    logic [31:0] out_data;
    logic        out_data_valid;
    logic        out_data_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending output beats plus interpolation history.
    logic [31:0] mq[$];
    logic [31:0] got[$];
    longint      m_prev = 0;
    longint      m_l    = 1;

    interp_hold_expander #(
        .IN_DATA_WIDTH (16),
        .OUT_DATA_WIDTH(32),
        .FACTOR_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .interp_factor (interp_factor),
        .in_data       (in_data),
        .in_data_valid (in_data_valid),
        .in_data_ready (in_data_ready),
        .out_data      (out_data),
        .out_data_valid(out_data_valid),
        .out_data_ready(out_data_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected burst for one accepted sample, straight from the ramp formula.
    task automatic model_push(input longint f, input logic [15:0] v);
        longint l;
        longint cur;
        longint x;
        l   = f + 1;
        cur = longint'($signed(v));
        if (l != m_l) m_prev = 0;
        for (longint k = 1; k <= l; k++) begin
            x = m_prev * l + k * (cur - m_prev);
            mq.push_back(32'(x));
        end
        m_prev = cur;
        m_l    = l;
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", {63'd0, out_data_valid}, 64'd0);
            check("rst_ready", {63'd0, in_data_ready}, 64'd0);
            mq.delete();
            m_prev = 0;
            m_l    = 1;
        end else begin
            logic exp_ready;
            exp_ready = (mq.size() == 0) || (mq.size() == 1 && out_data_ready);
            check("in_ready", {63'd0, in_data_ready}, {63'd0, exp_ready});
            check("out_valid", {63'd0, out_data_valid}, {63'd0, mq.size() > 0});
            if (out_data_valid && mq.size() > 0)
                check("out_data", {32'd0, out_data}, {32'd0, mq[0]});
            if (out_data_valid && out_data_ready) begin
                got.push_back(out_data);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (in_data_valid && in_data_ready)
                model_push(longint'(interp_factor), in_data);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        got.delete();
    endtask

    task automatic send(input int f, input int v);
        int n;
        interp_factor = 16'(f);
        in_data       = 16'(v);
        in_data_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_data_ready && n < 70000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 70000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_data_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1 in_data_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || out_data_valid) && n < 70000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 70000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", mq.size());
        end
    endtask

    task automatic check_log(input string name, input int exp[]);
        check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, {32'd0, got[i]}, {32'd0, 32'(exp[i])});
    endtask

    initial begin
        int exp_ramp[] = '{100, 200, 300, 400, 500, 600, 700, 800, 500, 200, -100, -400};
        int exp_pass[] = '{5, -7, 32767, -32768};
        int exp_bp[]   = '{100, 200, 300, 400};
        int exp_fc[]   = '{50, 100, 40, 80, 120, 160};
        int exp_rm[]   = '{10, 20, 30, 40, 50, 60, 70, 80};

        rst            = 1'b0;
        interp_factor  = '0;
        in_data        = '0;
        in_data_valid  = 1'b0;
        out_data_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("reset_out_data", {32'd0, out_data}, 64'd0);
        check("reset_valid", {63'd0, out_data_valid}, 64'd0);
        do_reset();

        // Basic ramp, back-to-back inputs.
        send(3, 100);
        check("first_latency", {63'd0, out_data_valid}, 64'd1);
        send(3, 200);
        send(3, -100);
        drain();
        check_log("ramp", exp_ramp);

        // Pass-through.
        do_reset();
        send(0, 5);
        send(0, -7);
        send(0, 32767);
        send(0, -32768);
        drain();
        check_log("pass", exp_pass);

        // Backpressure at beat 2.
        do_reset();
        send(3, 100);
        @(posedge clk);
        #1 out_data_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_data", {32'd0, out_data}, 64'd200);
            check("stall_ready", {63'd0, in_data_ready}, 64'd0);
        end
        @(posedge clk);
        #1 out_data_ready = 1'b1;
        drain();
        check_log("backpressure", exp_bp);

        // Factor change resets history.
        do_reset();
        send(1, 50);
        send(3, 40);
        drain();
        check_log("factor_change", exp_fc);

        // Extremes: L = 65536, most negative input.
        do_reset();
        send(65535, -32768);
        drain();
        check("ext_len", 64'(got.size()), 64'd65536);
        if (got.size() == 65536) begin
            check("ext_first", {32'd0, got[0]}, {32'd0, 32'hFFFF8000});
            check("ext_last", {32'd0, got[65535]}, {32'd0, 32'h80000000});
        end

        // Reset mid-burst.
        do_reset();
        send(7, 1000);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", {63'd0, out_data_valid}, 64'd0);
        check("midrst_data", {32'd0, out_data}, 64'd0);
        check("midrst_ready", {63'd0, in_data_ready}, 64'd0);
        check("midrst_beats", 64'(got.size()), 64'd3);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        got.delete();
        send(7, 10);
        drain();
        check_log("after_reset", exp_rm);

        // Randomized traffic with mid-burst factor changes and backpressure.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_data_valid  = ($urandom_range(0, 2) != 0);
            interp_factor  = 16'($urandom_range(0, 4));
            in_data        = 16'($urandom);
            out_data_ready = ($urandom_range(0, 3) != 0);
        end
        in_data_valid  = 1'b0;
        out_data_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interp_hold_expander.md
Name: interp_hold_expander

Overview:
- Interpolating upsampler. It is the expansion counterpart of the team's block-sum decimator.
- Each accepted input sample produces L = interp_factor+1 output samples. The outputs ramp linearly from the previous input to the current input.
- Outputs are scaled by L and are not normalised, which matches the decimator's un-normalised sum convention.
- The block sits between a sample source and an AXI-Stream packer in the sample generator path. Ready/valid handshakes are used on both sides.

Parameters:
- IN_DATA_WIDTH, 16, signed input sample width.
- OUT_DATA_WIDTH, 32, signed output width. Must be at least IN_DATA_WIDTH+FACTOR_WIDTH.
- FACTOR_WIDTH, 16, width of interp_factor.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- interp_factor  in  FACTOR_WIDTH  L-1. Value 0 means pass-through (L=1).
- in_data  in  IN_DATA_WIDTH  signed input sample.
- in_data_valid  in  1  input sample valid.
- in_data_ready  out  1  block accepts in_data this cycle (combinational).
- out_data  out  OUT_DATA_WIDTH  signed interpolated sample (registered).
- out_data_valid  out  1  out_data valid (registered).
- out_data_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, acc=0, prev=0, delta=0, cnt=0, L_reg=1, out_data=0, out_data_valid=0. While rst is high, in_data_ready=0.
- Handshakes:
  - in_fire = in_data_valid & in_data_ready.
  - out_fire = out_data_valid & out_data_ready.
  - out_data and out_data_valid hold stable while out_data_valid=1 and out_data_ready=0.
- States:
  - IDLE: no output pending. in_data_ready=1.
  - RUN: emitting beats 1..L_reg. in_data_ready=1 only when cnt==L_reg and out_fire, which gives back-to-back bursts with no bubble.
- Load action, taken on in_fire from IDLE or from a last-beat RUN:
  - Latch L_new = interp_factor+1.
  - If L_new differs from L_reg: history reset, so prev_eff=0 and acc_eff=0. Otherwise prev_eff=prev and acc_eff=acc.
  - d = sext(in_data) - prev_eff, computed at IN_DATA_WIDTH+1 bits and then sign-extended to OUT_DATA_WIDTH.
  - Register updates: delta<=d, acc<=acc_eff+d, out_data<=acc_eff+d, out_data_valid<=1, cnt<=1, prev<=in_data, L_reg<=L_new, state<=RUN.
- Output sequence: beat k (k=1..L) carries prev_old*L + k*(cur-prev_old). The last beat equals cur*L exactly, so acc after a burst equals prev*L_reg. There are no multipliers; only the add chain is used.
- In RUN, on out_fire with cnt<L_reg: acc<=acc+delta, out_data<=acc+delta, cnt<=cnt+1.
- In RUN, on out_fire with cnt==L_reg:
  - If in_fire is also high in that cycle, perform the load action. Next cycle presents beat 1 of the new burst.
  - Otherwise out_data_valid<=0 and state<=IDLE. out_data holds its last value.
- Latency: in_fire to first out_data_valid is 1 cycle.
- Throughput: with out_data_ready held high, one output per cycle, including L=1 streaming.
- interp_factor is sampled only at in_fire. Changes mid-burst have no effect on the current burst.
- Arithmetic is two's complement and wraps modulo 2^OUT_DATA_WIDTH, with no saturation. No overflow occurs when the parameter constraint holds, including the -2^(IN-1) * 2^FACTOR_WIDTH corner.
- interp_factor at its maximum (all ones) gives L = 2^FACTOR_WIDTH. cnt and L_reg are FACTOR_WIDTH+1 bits wide.
- Reset asserted mid-burst: the burst is aborted immediately and out_data_valid drops asynchronously. History is cleared.

Test Plan:
- Basic ramp. After reset, interp_factor=3, out_data_ready=1. Inputs 100, 200, -100 back-to-back.
  - Required outputs: 100, 200, 300, 400, then 500, 600, 700, 800, then 500, 200, -100, -400.
  - 12 consecutive valid cycles with no bubbles. First valid appears 1 cycle after the first in_fire.
- Pass-through. interp_factor=0. Inputs 5, -7, 32767, -32768 on consecutive cycles.
  - Required outputs: 5, -7, 32767, -32768, one per cycle, each 1 cycle after its input.
  - in_data_ready stays high throughout.
- Backpressure. interp_factor=3, input 100. Hold out_data_ready=0 for 3 cycles at beat 2.
  - out_data stays 200 with valid high throughout the stall.
  - in_data_ready=0 during the stall. Sequence then resumes at 300, 400.
- Factor change. Run interp_factor=1 on input 50 (outputs 50, 100). Then set interp_factor=3 and input 40.
  - History resets. Required outputs: 40, 80, 120, 160.
- Extremes. interp_factor=65535 with input -32768 from reset.
  - Final beat equals -2147483648. Beat 65536 is flagged last.
  - in_data_ready asserts only on that beat.
- Reset mid-burst. interp_factor=7, input 1000. Assert rst after beat 3.
  - out_data_valid drops within the reset cycle with no clock edge needed. out_data=0.
  - Next input 10 with interp_factor=7 gives outputs 10, 20, …, 80.
